// File: rtl/pc_fetch_unit.sv
// Fetch / next-PC stage for the single-issue RV32I core: IDLE -> FETCH -> EXEC loop with HALT.
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned taken targets instead of masking them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [3:0]  pc_sel,
  input  logic [31:0] imm,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic        ex_stall,
  input  logic        halt,
  output logic        halted,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_BEQ  = 4'd1;
  localparam logic [3:0] SEL_BNE  = 4'd2;
  localparam logic [3:0] SEL_BLT  = 4'd3;
  localparam logic [3:0] SEL_BGE  = 4'd4;
  localparam logic [3:0] SEL_BLTU = 4'd5;
  localparam logic [3:0] SEL_BGEU = 4'd6;
  localparam logic [3:0] SEL_JAL  = 4'd7;
  localparam logic [3:0] SEL_JALR = 4'd8;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;

  logic        take_s;
  logic        trap_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;

  // Branch/jump resolution: SLT/SLTU result bit 0 carries the less-than outcome.
  always_comb begin
    take_s   = 1'b0;
    target_s = pc_q + imm;
    case (pc_sel)
      SEL_BEQ:             take_s = alu_zero;
      SEL_BNE:             take_s = ~alu_zero;
      SEL_BLT, SEL_BLTU:   take_s = alu_result[0];
      SEL_BGE, SEL_BGEU:   take_s = ~alu_result[0];
      SEL_JAL:             take_s = 1'b1;
      SEL_JALR: begin
        take_s   = 1'b1;
        target_s = {alu_result[31:1], 1'b0};
      end
      default:             take_s = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    trap_s    = take_s && (target_s[1:0] != 2'b00);
    next_pc_s = take_s ? target_s : pc_plus4;
`else
    trap_s    = 1'b0;
    next_pc_s = take_s ? (target_s & 32'hFFFF_FFFC) : pc_plus4;
`endif
  end

  // Next-state logic; output flags are derived from the state being entered so they register cleanly.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (ex_stall) begin
          state_d = S_EXEC;
        end else if (trap_s) begin
          // Faulting target is not loaded so pc still points at the offending instruction.
          misaligned_d = 1'b1;
          state_d      = S_HALT;
        end else begin
          pc_d    = next_pc_s;
          state_d = halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_EXEC);
    halted_d      = (state_d == S_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, reset/trap sequences, randomized instruction stream.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        nRst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_sel;
  logic [31:0] imm;
  logic        alu_zero;
  logic [31:0] alu_result;
  logic        ex_stall;
  logic        halt;
  logic        halted;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] rdata;
    int          ack_dly;
    int          stall_n;
    logic [3:0]  sel;
    logic [31:0] imm;
    logic        zero;
    logic [31:0] res;
    logic        hlt;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_sel     (pc_sel),
    .imm        (imm),
    .alu_zero   (alu_zero),
    .alu_result (alu_result),
    .ex_stall   (ex_stall),
    .halt       (halt),
    .halted     (halted),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] rdata, input int ack_dly, input int stall_n,
                              input logic [3:0] sel, input logic [31:0] im, input logic zero,
                              input logic [31:0] res, input logic hlt, input logic [31:0] exp_addr);
    vec_t v;
    v.rdata = rdata; v.ack_dly = ack_dly; v.stall_n = stall_n; v.sel = sel; v.imm = im;
    v.zero = zero; v.res = res; v.hlt = hlt; v.exp_addr = exp_addr;
    return v;
  endfunction

  // Reference next-PC from the ISA rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [3:0] s,
                                           input logic [31:0] im, input logic z,
                                           input logic [31:0] r, output bit mis);
    bit take;
    logic [31:0] tgt;
    tgt = p + im;
    mis = 1'b0;
    case (s)
      4'd1:       take = z;
      4'd2:       take = !z;
      4'd3, 4'd5: take = r[0];
      4'd4, 4'd6: take = !r[0];
      4'd7:       take = 1'b1;
      4'd8: begin take = 1'b1; tgt = r - (r % 32'd2); end
      default:    take = 1'b0;
    endcase
    if (!take) return p + 32'd4;
`ifdef MISALIGN_TRAP_EN
    if ((tgt % 32'd4) != 32'd0) begin
      mis = 1'b1;
      return p;
    end
    return tgt;
`else
    return tgt - (tgt % 32'd4);
`endif
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive don't-care values onto inputs that must only be sampled on the completing EXEC edge.
  task automatic junk();
    pc_sel     = 4'($urandom_range(0, 15));
    imm        = $urandom;
    alu_zero   = ($urandom_range(0, 1) == 1);
    alu_result = $urandom;
    halt       = ($urandom_range(0, 1) == 1);
  endtask

  task automatic do_reset();
    nRst = 1'b0; ex_stall = 1'b0; imem_ack = 1'b0;
    step();
    step();
    nRst = 1'b1;
    #1;
    chk1("idle_req", imem_req, 1'b0);
    @(negedge clk);
    model_pc = RST_PC;
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at a negedge after the completing EXEC edge.
  task automatic do_instr(input vec_t v, output bit stopped);
    logic [31:0] nxt;
    bit mis;
    chk1("fetch_req", imem_req, 1'b1);
    chk32("fetch_addr", imem_addr, v.exp_addr);
    chk1("fetch_ivalid", instr_valid, 1'b0);
    for (int i = 0; i < v.ack_dly; i++) begin
      junk(); imem_ack = 1'b0; imem_rdata = $urandom;
      step();
      chk1("wait_req", imem_req, 1'b1);
      chk32("wait_addr", imem_addr, v.exp_addr);
    end
    junk(); imem_ack = 1'b1; imem_rdata = v.rdata;
    step();
    imem_rdata = $urandom;
    chk1("exec_valid", instr_valid, 1'b1);
    chk32("exec_instr", instr, v.rdata);
    chk32("exec_pc", pc, v.exp_addr);
    chk32("exec_plus4", pc_plus4, v.exp_addr + 32'd4);
    chk1("exec_req", imem_req, 1'b0);
    for (int s = 0; s < v.stall_n; s++) begin
      junk(); halt = v.hlt; ex_stall = 1'b1; imem_ack = ($urandom_range(0, 1) == 1);
      step();
      chk1("stall_valid", instr_valid, 1'b1);
      chk32("stall_pc", pc, v.exp_addr);
      chk32("stall_instr", instr, v.rdata);
    end
    ex_stall = 1'b0; pc_sel = v.sel; imm = v.imm; alu_zero = v.zero; alu_result = v.res;
    halt = v.hlt; imem_ack = ($urandom_range(0, 1) == 1);
    nxt = ref_next(v.exp_addr, v.sel, v.imm, v.zero, v.res, mis);
    step();
    junk(); imem_ack = 1'b0;
    stopped = v.hlt || mis;
    chk32("next_pc", pc, nxt);
    chk1("misaligned", misaligned, mis);
    chk1("halted", halted, stopped);
    chk1("post_valid", instr_valid, 1'b0);
    chk1("post_req", imem_req, !stopped);
    model_pc = nxt;
  endtask

  initial begin
    bit stp;
    vec_t v;
    nRst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; pc_sel = 4'd0; imm = 32'd0;
    alu_zero = 1'b0; alu_result = 32'd0; ex_stall = 1'b0; halt = 1'b0;
    #1 nRst = 1'b0;
    #1;
    chk32("rst_pc", pc, RST_PC);
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_instr", instr, 32'd0);
    chk1("rst_ivalid", instr_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_mis", misaligned, 1'b0);

    tbl.push_back(mk(32'hA000_0001, 0, 0, 4'd0, 32'd0,         1'b0, 32'd0,         1'b0, 32'h0000_0100));
    tbl.push_back(mk(32'hA000_0002, 0, 0, 4'd0, 32'd0,         1'b0, 32'd0,         1'b0, 32'h0000_0104));
    tbl.push_back(mk(32'hA000_0003, 0, 0, 4'd1, 32'hFFFF_FFF8, 1'b1, 32'd0,         1'b0, 32'h0000_0108));
    tbl.push_back(mk(32'hA000_0004, 3, 0, 4'd0, 32'd0,         1'b0, 32'd0,         1'b0, 32'h0000_0100));
    tbl.push_back(mk(32'hA000_0005, 0, 0, 4'd0, 32'd0,         1'b0, 32'd0,         1'b0, 32'h0000_0104));
    tbl.push_back(mk(32'hA000_0006, 0, 0, 4'd1, 32'hFFFF_FFF8, 1'b0, 32'd0,         1'b0, 32'h0000_0108));
    tbl.push_back(mk(32'hA000_0007, 1, 0, 4'd7, 32'hFFFF_FFF4, 1'b0, 32'd0,         1'b0, 32'h0000_010C));
    tbl.push_back(mk(32'hA000_0008, 0, 0, 4'd5, 32'h0000_0020, 1'b0, 32'd1,         1'b0, 32'h0000_0100));
    tbl.push_back(mk(32'hA000_0009, 0, 1, 4'd4, 32'h0000_0040, 1'b0, 32'd1,         1'b0, 32'h0000_0120));
    tbl.push_back(mk(32'hA000_000A, 0, 0, 4'd8, 32'd0,         1'b0, 32'h0000_2001, 1'b0, 32'h0000_0124));
    tbl.push_back(mk(32'hA000_000B, 0, 0, 4'd2, 32'h0000_0010, 1'b0, 32'd0,         1'b0, 32'h0000_2000));
    tbl.push_back(mk(32'hA000_000C, 2, 0, 4'd3, 32'h0000_0100, 1'b0, 32'd0,         1'b0, 32'h0000_2010));
    tbl.push_back(mk(32'hA000_000D, 0, 0, 4'd6, 32'hFFFF_FFEC, 1'b0, 32'd0,         1'b0, 32'h0000_2014));
    tbl.push_back(mk(32'hA000_000E, 0, 0, 4'd12, 32'h0000_0040, 1'b1, 32'd1,        1'b0, 32'h0000_2000));
    tbl.push_back(mk(32'hA000_000F, 0, 0, 4'd8, 32'd0,         1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_2004));
    tbl.push_back(mk(32'hA000_0010, 0, 0, 4'd0, 32'd0,         1'b0, 32'd0,         1'b0, 32'hFFFF_FFFC));
    tbl.push_back(mk(32'hA000_0011, 0, 2, 4'd0, 32'd0,         1'b0, 32'd0,         1'b1, 32'h0000_0000));

    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      do_instr(tbl[i], stp);
    end
    chk1("tbl_halted", halted, 1'b1);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      step();
      chk1("halt_req", imem_req, 1'b0);
      chk1("halt_sticky", halted, 1'b1);
      chk32("halt_pc", pc, 32'h0000_0004);
    end

    // Asynchronous reset in the middle of a fetch at 0x200.
    do_reset();
    do_instr(mk(32'hB000_0001, 0, 0, 4'd7, 32'h0000_0100, 1'b0, 32'd0, 1'b0, RST_PC), stp);
    imem_ack = 1'b0;
    step();
    chk32("midrst_addr", imem_addr, 32'h0000_0200);
    #2 nRst = 1'b0;
    #1;
    chk1("midrst_req", imem_req, 1'b0);
    chk32("midrst_pc", pc, RST_PC);
    @(negedge clk);
    nRst = 1'b1;
    #1;
    chk1("midrst_idle", imem_req, 1'b0);
    @(negedge clk);
    do_instr(mk(32'hB000_0002, 0, 0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, RST_PC), stp);

    // JALR to a target still misaligned after clearing bit 0.
    do_reset();
    do_instr(mk(32'hC000_0001, 0, 0, 4'd8, 32'd0, 1'b0, 32'h0000_2002, 1'b0, RST_PC), stp);
`ifdef MISALIGN_TRAP_EN
    chk32("trap_pc", pc, RST_PC);
    step();
    chk1("trap_mis_sticky", misaligned, 1'b1);
    chk1("trap_halted", halted, 1'b1);
`else
    chk32("jalr_mask_pc", pc, 32'h0000_2000);
    chk1("jalr_mask_mis", misaligned, 1'b0);
`endif

    // Randomized instruction stream against the reference model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      v.rdata   = $urandom;
      v.ack_dly = $urandom_range(0, 2);
      v.stall_n = $urandom_range(0, 2);
      v.sel     = 4'($urandom_range(0, 15));
      v.imm     = $urandom;
      if ($urandom_range(0, 3) != 0) v.imm = v.imm & 32'hFFFF_FFFC;
      v.zero    = ($urandom_range(0, 1) == 1);
      v.res     = $urandom;
      v.hlt     = ($urandom_range(0, 15) == 0);
      v.exp_addr = model_pc;
      do_instr(v, stp);
      if (stp) begin
        step();
        chk1("rnd_halt_req", imem_req, 1'b0);
        chk1("rnd_halt_sticky", halted, 1'b1);
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch/next-PC stage that sits around the ALU in the single-issue RV32I core.
- Holds the program counter and fetches each instruction over a req/ack instruction-memory handshake.
- Presents the instruction to decode/execute.
- Uses the ALU's zero flag and ALUResult to decide the next PC for branches, JAL and JALR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address, always equal to pc
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction word
- instr  output  32  registered instruction for decode
- instr_valid  output  1  instr is being executed this cycle
- pc  output  32  current PC
- pc_plus4  output  32  pc+4 (combinational), used as link value
- pc_sel  input  4  next-PC select: 0 SEQ, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR; 9–15 are treated as SEQ
- imm  input  32  sign-extended branch/JAL offset
- alu_zero  input  1  ALU zero flag (ALU configured for SUB on BEQ/BNE)
- alu_result  input  32  ALU result (SLT/SLTU for BLT..BGEU; rs1+imm for JALR)
- ex_stall  input  1  execute not finished; hold current instruction
- halt  input  1  stop fetching after the current instruction
- halted  output  1  unit is in HALT
- misaligned  output  1  misaligned target trapped (only with the optional feature)

Behaviour:
- Reset (asynchronous, nRst low): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, misaligned=0.
- Reset takes effect immediately, including mid-fetch; imem_req drops in the same cycle.
- States:
  - IDLE: goes to FETCH on the next edge, unconditionally.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until ack. On an edge with imem_ack=1: instr<=imem_rdata, go to EXEC.
  - EXEC: instr_valid=1, imem_req=0.
    - Edge with ex_stall=1: stay in EXEC; pc, instr and instr_valid held.
    - Edge with ex_stall=0 and halt=0: pc<=next_pc, go to FETCH.
    - Edge with ex_stall=0 and halt=1: pc<=next_pc, go to HALT.
  - HALT: imem_req=0, instr_valid=0, halted=1. Only reset exits.
- Timing:
  - Minimum 2 cycles per instruction (ack in the first FETCH cycle).
  - imem_ack outside FETCH is ignored.
  - pc_sel, imm, alu_zero and alu_result are sampled only on the completing EXEC edge.
- next_pc, all arithmetic modulo 2^32 (0xFFFF_FFFC+4 wraps to 0):
  - SEQ: pc+4.
  - BEQ: pc+imm if alu_zero, else pc+4.
  - BNE: pc+imm if !alu_zero, else pc+4.
  - BLT and BLTU: pc+imm if alu_result[0], else pc+4.
  - BGE and BGEU: pc+imm if !alu_result[0], else pc+4.
  - JAL: pc+imm.
  - JALR: alu_result with bit0 cleared.
- Simultaneous events: ex_stall takes priority over halt. halt is only acted on at the edge where ex_stall=0.
- Targets whose bits [1:0] are nonzero after the JALR bit0 clear are handled per the optional feature.

Optional Feature:
- MISALIGN_TRAP_EN
- Defined:
  - A taken target with bits [1:0] != 0 is not loaded; pc keeps the faulting instruction's address.
  - State goes to HALT; misaligned=1 (sticky until reset).
- Undefined:
  - Target bits [1:0] are forced to 0 and execution continues.
  - misaligned is tied to 0.

Test Plan:
- RESET_PC=0x100, reset released, ack on the first FETCH cycle, pc_sel=SEQ -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid is a 1-cycle pulse every 2 cycles; instr equals each rdata.
- At pc=0x108: pc_sel=BEQ, imm=-8 -> alu_zero=1 gives next pc 0x100; alu_zero=0 gives 0x10C. BLTU with alu_result=1 and imm=0x20 at 0x100 -> 0x120.
- JALR, alu_result=0x2001 -> pc 0x2000. alu_result=0x2002: without the macro pc=0x2000; with MISALIGN_TRAP_EN pc stays at the JALR address, halted=1, misaligned=1.
- Wait states: ack delayed 3 cycles -> imem_req/imem_addr held 4 cycles. ex_stall=1 for 2 EXEC cycles with halt=1 -> pc held, instr_valid high 3 cycles, then HALT, imem_req stays 0.
- pc=0xFFFF_FFFC, SEQ -> next fetch address 0x0000_0000.
- nRst pulled low mid-FETCH at pc=0x200 -> imem_req=0 and pc=RESET_PC asynchronously; after release, IDLE then FETCH at RESET_PC.
